ysyx_22040632_ibuf: RTL and testbench

- Instruction buffer between the instruction fetch unit (upstream) and the decode stage (downstream).
- Queues fetched {pc, inst} pairs with valid/ready handshakes on both sides, so decode stalls do not drop fetched instructions.
- Drops all queued entries on a control-flow redirect (flush) so that no wrong-path instruction reaches decode.

---
 rtl/ysyx_22040632_ibuf.sv | 92 +++++++++
 tb/tb_ysyx_22040632_ibuf.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22040632_ibuf.sv
// Instruction buffer between fetch and decode: a circular queue of {pc, inst} pairs that is emptied on flush.
// Define IBUF_BYPASS_EN to forward an input straight to decode when the queue is empty.
module ysyx_22040632_ibuf #(
   parameter int DEPTH  = 4,
   parameter int PC_W   = 64,
   parameter int INST_W = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [PC_W-1:0]            in_pc,
   input  logic [INST_W-1:0]          in_inst,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [PC_W-1:0]            out_pc,
   output logic [INST_W-1:0]          out_inst,
   output logic                       out_misalign,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   logic [PC_W-1:0]   pc_mem_q   [DEPTH];
   logic [INST_W-1:0] inst_mem_q [DEPTH];
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;

   logic empty, full, push, pop, bypass_fire;

   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

   // A forwarded entry is consumed in flight and must never be written.
`ifdef IBUF_BYPASS_EN
   assign bypass_fire = empty && in_valid && out_ready && !flush;
`else
   assign bypass_fire = 1'b0;
`endif

   assign in_ready = !full;
   assign push     = in_valid && !full && !flush && !bypass_fire;
   assign pop      = !empty && out_ready && !flush;
   assign count    = wr_ptr_q - rd_ptr_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !rst) begin
         pc_mem_q[wr_ptr_q[AW-1:0]]   <= in_pc;
         inst_mem_q[wr_ptr_q[AW-1:0]] <= in_inst;
      end
   end

   always_comb begin
      out_valid = !empty;
      out_pc    = empty ? '0 : pc_mem_q[rd_ptr_q[AW-1:0]];
      out_inst  = empty ? '0 : inst_mem_q[rd_ptr_q[AW-1:0]];
`ifdef IBUF_BYPASS_EN
      if (empty && in_valid && !flush) begin
         out_valid = 1'b1;
         out_pc    = in_pc;
         out_inst  = in_inst;
      end
`endif
      out_misalign = out_valid && (out_pc[1:0] != 2'b00);
   end

endmodule

// File: tb/tb_ysyx_22040632_ibuf.sv
// Directed bench for ysyx_22040632_ibuf: expected entries are queued at issue and checked by a monitor.
module tb_ysyx_22040632_ibuf;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [63:0] in_pc = '0;
   logic [31:0] in_inst = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [63:0] out_pc;
   logic [31:0] out_inst;
   logic        out_misalign;
   logic [2:0]  count;

   typedef struct {
      logic [63:0] pc;
      logic [31:0] inst;
   } entry_t;

   entry_t exp_q[$];
   int total = 0;
   int bad = 0;
   int delivered = 0;

   ysyx_22040632_ibuf #(.DEPTH(4), .PC_W(64), .INST_W(32)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
      .out_misalign(out_misalign), .count(count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [63:0] pc, input logic [31:0] inst, input bit expect_accept);
      in_valid = 1'b1;
      in_pc    = pc;
      in_inst  = inst;
      if (expect_accept) exp_q.push_back('{pc: pc, inst: inst});
   endtask

   // Monitor: every handshake the DUT will complete at the next edge must match the queue head.
   always @(negedge clk) begin
      if (!rst && !flush && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_delivery actual=%h required=none", out_pc);
         end else begin
            entry_t e;
            e = exp_q.pop_front();
            chk("mon_pc", out_pc, e.pc);
            chk("mon_inst", {32'b0, out_inst}, {32'b0, e.inst});
            chk("mon_misalign", {63'b0, out_misalign}, {63'b0, (e.pc[1:0] != 2'b00)});
            delivered++;
         end
      end
   end

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_out_valid"}, {63'b0, out_valid}, 64'd0);
      chk({tag, "_in_ready"}, {63'b0, in_ready}, 64'd1);
      chk({tag, "_count"}, {61'b0, count}, 64'd0);
      chk({tag, "_out_pc"}, out_pc, 64'd0);
      chk({tag, "_out_inst"}, {32'b0, out_inst}, 64'd0);
      chk({tag, "_misalign"}, {63'b0, out_misalign}, 64'd0);
   endtask

   initial begin
      int d0;
      step();
      step();
      rst = 1'b0;
      @(negedge clk);
      chk_reset_outputs("reset");

      // Single push, held at the output while decode stalls.
      step();
      drive(64'h8000_0000, 32'h0000_0413, 1'b1);
`ifndef IBUF_BYPASS_EN
      @(negedge clk);
      chk("latency_no_comb_path", {63'b0, out_valid}, 64'd0);
`endif
      step();
      in_valid = 1'b0;
      @(negedge clk);
      chk("t1_out_valid", {63'b0, out_valid}, 64'd1);
      chk("t1_out_pc", out_pc, 64'h8000_0000);
      chk("t1_out_inst", {32'b0, out_inst}, 64'h0000_0413);
      chk("t1_count", {61'b0, count}, 64'd1);

      // Fill to full; a fifth entry must be refused.
      for (int i = 1; i < 4; i++) begin
         step();
         drive(64'h8000_0000 + 64'(4 * i), 32'h0000_0013 + 32'(i), 1'b1);
      end
      step();
      drive(64'h8000_0010, 32'hdead_beef, 1'b0);
      @(negedge clk);
      chk("full_count", {61'b0, count}, 64'd4);
      chk("full_in_ready", {63'b0, in_ready}, 64'd0);
      chk("full_head_stable", out_pc, 64'h8000_0000);
      step();
      in_valid = 1'b0;
      @(negedge clk);
      chk("full_refused_count", {61'b0, count}, 64'd4);
      step();
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) step();
      @(negedge clk);
      chk("drain_out_valid", {63'b0, out_valid}, 64'd0);
      chk("drain_count", {61'b0, count}, 64'd0);
      out_ready = 1'b0;

      // Streaming with two entries in flight; pointers wrap several times.
      step();
      drive(64'h8000_1000, 32'h0000_1013, 1'b1);
      step();
      drive(64'h8000_1004, 32'h0000_1113, 1'b1);
      step();
      in_valid = 1'b0;
      d0 = delivered;
      out_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         drive(64'h8000_1008 + 64'(4 * i), 32'h0000_2000 + 32'(i), 1'b1);
         @(negedge clk);
         chk("stream_count", {61'b0, count}, 64'd2);
         step();
      end
      in_valid = 1'b0;
      step();
      step();
      @(negedge clk);
      chk("stream_delivered", 64'(delivered - d0), 64'd22);
      chk("stream_empty", {63'b0, out_valid}, 64'd0);
      out_ready = 1'b0;

      // Flush with a push in the same cycle: the push is wrong-path.
      step();
      for (int i = 0; i < 3; i++) begin
         drive(64'h8000_0040 + 64'(4 * i), 32'h0000_0040 + 32'(i), 1'b1);
         step();
      end
      flush = 1'b1;
      drive(64'h8000_0100, 32'h0000_0100, 1'b0);
      exp_q.delete();
      step();
      flush = 1'b0;
      drive(64'h8000_0200, 32'h0000_0200, 1'b1);
      @(negedge clk);
      chk("flush_count", {61'b0, count}, 64'd0);
      chk("flush_out_valid", {63'b0, out_valid}, 64'd0);
      chk("flush_in_ready", {63'b0, in_ready}, 64'd1);
      step();
      in_valid = 1'b0;
      @(negedge clk);
      chk("post_flush_valid", {63'b0, out_valid}, 64'd1);
      chk("post_flush_pc", out_pc, 64'h8000_0200);
      step();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;

      // Reset mid-stream with decode ready, then a misaligned entry.
      drive(64'h8000_0300, 32'h0000_0300, 1'b1);
      step();
      drive(64'h8000_0304, 32'h0000_0304, 1'b1);
      step();
      in_valid = 1'b0;
      rst = 1'b1;
      out_ready = 1'b1;
      exp_q.delete();
      step();
      rst = 1'b0;
      out_ready = 1'b0;
      @(negedge clk);
      chk_reset_outputs("midrst");
      step();
      drive(64'h8000_0002, 32'h0000_0013, 1'b1);
      step();
      in_valid = 1'b0;
      @(negedge clk);
      chk("misalign_flag", {63'b0, out_misalign}, 64'd1);
      chk("misalign_pc", out_pc, 64'h8000_0002);
      step();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;

`ifdef IBUF_BYPASS_EN
      // Zero-latency forward, then a forward that also has to be stored.
      out_ready = 1'b1;
      drive(64'h8000_0010, 32'h0000_0510, 1'b1);
      @(negedge clk);
      chk("byp_valid", {63'b0, out_valid}, 64'd1);
      chk("byp_pc", out_pc, 64'h8000_0010);
      chk("byp_count", {61'b0, count}, 64'd0);
      step();
      in_valid = 1'b0;
      @(negedge clk);
      chk("byp_after_count", {61'b0, count}, 64'd0);
      chk("byp_after_valid", {63'b0, out_valid}, 64'd0);
      step();
      out_ready = 1'b0;
      drive(64'h8000_0014, 32'h0000_0514, 1'b1);
      @(negedge clk);
      chk("byp_stall_valid", {63'b0, out_valid}, 64'd1);
      chk("byp_stall_pc", out_pc, 64'h8000_0014);
      step();
      in_valid = 1'b0;
      @(negedge clk);
      chk("byp_stall_count", {61'b0, count}, 64'd1);
      step();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      @(negedge clk);
      chk("byp_once_valid", {63'b0, out_valid}, 64'd0);
`endif

      step();
      chk("leftover_expected", 64'(exp_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
